ibex_mul_share_arb: RTL and testbench

IBEX_MUL_SHARE_ARB -- requirements
Module: ibex_mul_share_arb

---
 rtl/ibex_pkg.sv | 32 +++
 rtl/ibex_mul17_pipe.sv | 80 ++++++++
 rtl/ibex_mul_share_arb.sv | 114 +++++++++++
 tb/tb_ibex_mul_share_arb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the multiplier-sharing arbiter and its 17x17 pipeline.
package ibex_pkg;

    localparam int unsigned MulOpW  = 17;
    localparam int unsigned MulResW = 2 * MulOpW;

    // Arbiter ownership state: free, or held by one requester across beats.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_M = 2'd1,
        LOCK_P = 2'd2
    } mul_arb_state_e;

    // Which requester a beat belongs to; travels down the pipe as a tag.
    typedef enum logic {
        OWNER_M = 1'b0,
        OWNER_P = 1'b1
    } mul_owner_e;

    // One accepted beat as it sits in stage 1.
    typedef struct packed {
        mul_owner_e        tag;
        logic [MulOpW-1:0] op_a;
        logic [MulOpW-1:0] op_b;
    } mul_beat_t;

    // Lock state that corresponds to a given owner.
    function automatic mul_arb_state_e lock_state(input mul_owner_e owner);
        return (owner == OWNER_P) ? LOCK_P : LOCK_M;
    endfunction

endpackage

// File: rtl/ibex_mul17_pipe.sv
// Two-stage signed 17x17 multiplier: stage 1 holds operands+tag,
// stage 2 holds the 34-bit product+tag. Flush kills both stages.
module ibex_mul17_pipe
    import ibex_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    input  mul_owner_e         in_tag_i,
    input  logic [MulOpW-1:0]  op_a_i,
    input  logic [MulOpW-1:0]  op_b_i,
    output logic               out_valid_o,
    output mul_owner_e         out_tag_o,
    output logic [MulResW-1:0] product_o,
    output logic               busy_o
);

    logic                s1_vld_q, s1_vld_d;
    mul_beat_t           s1_beat_q, s1_beat_d;
    logic                s2_vld_q, s2_vld_d;
    mul_owner_e          s2_tag_q, s2_tag_d;
    logic [MulResW-1:0]  s2_prod_q, s2_prod_d;
    logic signed [MulResW-1:0] prod;
    logic                s1_adv;

    // Stage 1 captures a beat; operand regs hold when idle to avoid toggling.
    always_comb begin
        s1_vld_d  = in_valid_i & ~flush_i;
        s1_beat_d = s1_beat_q;
        if (in_valid_i) begin
            s1_beat_d = '{tag: in_tag_i, op_a: op_a_i, op_b: op_b_i};
        end
    end

    // Full-width signed product; the product register only loads on a live
    // beat so the shared result bus keeps its last value otherwise.
    always_comb begin
        prod      = $signed({{MulOpW{s1_beat_q.op_a[MulOpW-1]}}, s1_beat_q.op_a}) *
                    $signed({{MulOpW{s1_beat_q.op_b[MulOpW-1]}}, s1_beat_q.op_b});
        s1_adv    = s1_vld_q & ~flush_i;
        s2_vld_d  = s1_adv;
        s2_tag_d  = s2_tag_q;
        s2_prod_d = s2_prod_q;
        if (s1_adv) begin
            s2_tag_d  = s1_beat_q.tag;
            s2_prod_d = prod;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q  <= 1'b0;
            s1_beat_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_beat_q <= s1_beat_d;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_vld_q  <= 1'b0;
            s2_tag_q  <= OWNER_M;
            s2_prod_q <= '0;
        end else begin
            s2_vld_q  <= s2_vld_d;
            s2_tag_q  <= s2_tag_d;
            s2_prod_q <= s2_prod_d;
        end
    end

    assign out_valid_o = s2_vld_q;
    assign out_tag_o   = s2_tag_q;
    assign product_o   = s2_prod_q;
    assign busy_o      = s1_vld_q | s2_vld_q;

endmodule

// File: rtl/ibex_mul_share_arb.sv
// Arbitrates one 17x17 multiplier between the RV32M multdiv (M) and the
// P-ext ALU (P): round robin when free, sticky ownership while locked.
module ibex_mul_share_arb
    import ibex_pkg::*;
#(
    parameter int unsigned MulLatency = 2,
    parameter bit          LockEn     = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               m_req_i,
    input  logic               p_req_i,
    input  logic               m_lock_i,
    input  logic               p_lock_i,
    input  logic [MulOpW-1:0]  m_op_a_i,
    input  logic [MulOpW-1:0]  m_op_b_i,
    input  logic [MulOpW-1:0]  p_op_a_i,
    input  logic [MulOpW-1:0]  p_op_b_i,
    output logic               m_gnt_o,
    output logic               p_gnt_o,
    output logic               m_rvalid_o,
    output logic               p_rvalid_o,
    output logic [MulResW-1:0] result_o,
    input  logic               flush_i,
    output logic               busy_o
);

    // The pipe below is hard-wired to two stages.
    if (MulLatency != 2) begin : g_bad_latency
        $error("ibex_mul_share_arb: only MulLatency == 2 is supported");
    end

    mul_arb_state_e     state_q, state_d;
    mul_owner_e         last_gnt_q, last_gnt_d;
    logic               gnt_m, gnt_p, gnt_any, gnt_lock;
    mul_owner_e         gnt_owner;
    logic [MulOpW-1:0]  gnt_op_a, gnt_op_b;
    logic               pipe_vld, pipe_busy;
    mul_owner_e         pipe_tag;
    logic [MulResW-1:0] pipe_prod;

    // Grant decision: flush and reset suppress all grants; a lock owner
    // excludes the other side even when the owner is not requesting.
    always_comb begin
        gnt_m = 1'b0;
        gnt_p = 1'b0;
        if (rst_ni && !flush_i) begin
            unique case (state_q)
                LOCK_M: gnt_m = m_req_i;
                LOCK_P: gnt_p = p_req_i;
                default: begin
                    if (m_req_i && p_req_i) begin
                        gnt_m = (last_gnt_q == OWNER_P);
                        gnt_p = (last_gnt_q == OWNER_M);
                    end else begin
                        gnt_m = m_req_i;
                        gnt_p = p_req_i;
                    end
                end
            endcase
        end
    end

    // Next ownership state and round-robin pointer; flush frees the unit
    // but leaves the fairness pointer alone.
    always_comb begin
        gnt_any    = gnt_m | gnt_p;
        gnt_owner  = gnt_p ? OWNER_P : OWNER_M;
        gnt_lock   = (gnt_p ? p_lock_i : m_lock_i) & LockEn;
        gnt_op_a   = gnt_p ? p_op_a_i : m_op_a_i;
        gnt_op_b   = gnt_p ? p_op_b_i : m_op_b_i;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (gnt_any) begin
            last_gnt_d = gnt_owner;
            state_d    = gnt_lock ? lock_state(gnt_owner) : IDLE;
        end
    end

    // Arbiter state; P is the reset "last winner" so M wins first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_gnt_q <= OWNER_P;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    ibex_mul17_pipe u_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (gnt_any),
        .in_tag_i    (gnt_owner),
        .op_a_i      (gnt_op_a),
        .op_b_i      (gnt_op_b),
        .out_valid_o (pipe_vld),
        .out_tag_o   (pipe_tag),
        .product_o   (pipe_prod),
        .busy_o      (pipe_busy)
    );

    assign m_gnt_o    = gnt_m;
    assign p_gnt_o    = gnt_p;
    assign m_rvalid_o = pipe_vld & (pipe_tag == OWNER_M);
    assign p_rvalid_o = pipe_vld & (pipe_tag == OWNER_P);
    assign result_o   = pipe_prod;
    assign busy_o     = pipe_busy | (state_q != IDLE);

endmodule

// File: tb/tb_ibex_mul_share_arb.sv
// Scoreboard bench for ibex_mul_share_arb: directed scenarios then random
// traffic, with an arbitration/product reference model.
module tb_ibex_mul_share_arb;

    localparam logic [63:0] MASK34 = 64'h3_FFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m_req_i = 1'b0, p_req_i = 1'b0;
    logic        m_lock_i = 1'b0, p_lock_i = 1'b0;
    logic [16:0] m_op_a_i = '0, m_op_b_i = '0, p_op_a_i = '0, p_op_b_i = '0;
    logic        flush_i = 1'b0;
    logic        m_gnt_o, p_gnt_o, m_rvalid_o, p_rvalid_o, busy_o;
    logic [33:0] result_o;

    ibex_mul_share_arb dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .p_req_i    (p_req_i),
        .m_lock_i   (m_lock_i),
        .p_lock_i   (p_lock_i),
        .m_op_a_i   (m_op_a_i),
        .m_op_b_i   (m_op_b_i),
        .p_op_a_i   (p_op_a_i),
        .p_op_b_i   (p_op_b_i),
        .m_gnt_o    (m_gnt_o),
        .p_gnt_o    (p_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .p_rvalid_o (p_rvalid_o),
        .result_o   (result_o),
        .flush_i    (flush_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          own_p;
        logic [33:0] res;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          lock_own = 0;   // 0 none, 1 M, 2 P
    bit          last_p = 1'b1;
    logic [33:0] last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic longint sx(input int v);
        return ((v & 'h10000) != 0) ? longint'(v & 'h1FFFF) - 131072 : longint'(v & 'h1FFFF);
    endfunction

    // One cycle of stimulus plus grant/busy checks and scoreboard update.
    task automatic step(input int mr, input int ml, input int ma, input int mb,
                        input int pr, input int pl, input int pa, input int pb,
                        input int fl, output bit gm, output bit gp);
        bit em, ep;
        @(posedge clk_i); #1;
        m_req_i = (mr != 0); m_lock_i = (ml != 0); m_op_a_i = 17'(ma); m_op_b_i = 17'(mb);
        p_req_i = (pr != 0); p_lock_i = (pl != 0); p_op_a_i = 17'(pa); p_op_b_i = 17'(pb);
        flush_i = (fl != 0);
        @(negedge clk_i);
        chk("busy", 64'(busy_o), 64'(lock_own != 0 || q.size() > 0));
        em = 1'b0; ep = 1'b0;
        if (fl == 0) begin
            if (lock_own == 1)      em = (mr != 0);
            else if (lock_own == 2) ep = (pr != 0);
            else if (mr != 0 && pr != 0) begin
                em = last_p; ep = !last_p;
            end else begin
                em = (mr != 0); ep = (pr != 0);
            end
        end
        chk("m_gnt", 64'(m_gnt_o), 64'(em));
        chk("p_gnt", 64'(p_gnt_o), 64'(ep));
        gm = em; gp = ep;
        if (fl != 0) begin
            lock_own = 0;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else if (em || ep) begin
            exp_t e;
            last_p   = ep;
            lock_own = ((ep ? pl : ml) != 0) ? (ep ? 2 : 1) : 0;
            e.due    = cyc + 2;
            e.own_p  = ep;
            e.res    = ep ? 34'(sx(pa) * sx(pb)) : 34'(sx(ma) * sx(mb));
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bit gm, gp;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, gm, gp);
    endtask

    // Asynchronous reset mid-cycle; outputs must drop at once.
    task automatic do_reset(input bit mr);
        @(posedge clk_i); #1;
        rst_ni = 1'b0; m_req_i = mr; p_req_i = 1'b0; flush_i = 1'b0;
        m_op_a_i = 17'd3; m_op_b_i = 17'd3;
        #1;
        chk("rst_m_gnt", 64'(m_gnt_o), 64'd0);
        chk("rst_p_gnt", 64'(p_gnt_o), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
        chk("rst_p_rvalid", 64'(p_rvalid_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        q.delete();
        lock_own = 0; last_p = 1'b1; last_res = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1; m_req_i = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a result is due or presented.
    always @(negedge clk_i) begin
        exp_t e;
        bit   due_now;
        #1;
        if (rst_ni) begin
            due_now = (q.size() > 0) && (q[0].due == cyc);
            if (due_now) begin
                e = q.pop_front();
                chk("m_rvalid", 64'(m_rvalid_o), 64'(!e.own_p));
                chk("p_rvalid", 64'(p_rvalid_o), 64'(e.own_p));
                chk("result", 64'(result_o), 64'(e.res) & MASK34);
                last_res = e.res;
            end else begin
                chk("m_rvalid", 64'(m_rvalid_o), 64'd0);
                chk("p_rvalid", 64'(p_rvalid_o), 64'd0);
                chk("result_hold", 64'(result_o), 64'(last_res));
            end
        end
    end

    function automatic int rnd_op();
        case ($urandom_range(0, 7))
            0: return 'h10000;
            1: return 'h0FFFF;
            2: return 'h1FFFF;
            3: return 0;
            default: return int'($urandom_range(0, 'h1FFFF));
        endcase
    endfunction

    initial begin
        bit gm, gp;
        int mp, ml, ma, mb, pp, pl, pa, pb, fl;

        do_reset(1'b1);

        // Contention right after reset: M first, then P; 3*5 each.
        step(1, 0, 3, 5, 1, 0, 3, 5, 0, gm, gp);
        step(0, 0, 0, 0, 1, 0, 3, 5, 0, gm, gp);
        idle(3);

        // M holds a 4-beat lock while P waits, P granted right after.
        repeat (3) step(1, 1, 7, 9, 1, 0, 2, 2, 0, gm, gp);
        step(1, 0, 7, 9, 1, 0, 2, 2, 0, gm, gp);
        step(0, 0, 0, 0, 1, 0, 2, 2, 0, gm, gp);
        idle(3);

        // Fully pipelined stream of -1 * 1.
        repeat (8) step(1, 0, 'h1FFFF, 1, 0, 0, 0, 0, 0, gm, gp);
        idle(3);

        // Flush the cycle after a grant kills the beat.
        step(1, 0, 4, 4, 0, 0, 0, 0, 0, gm, gp);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, gm, gp);
        idle(3);

        // Flush with a request in the same cycle: flush wins.
        step(1, 0, 5, 6, 0, 0, 0, 0, 1, gm, gp);
        step(1, 0, 5, 6, 0, 0, 0, 0, 0, gm, gp);
        idle(3);

        // Reset a cycle after a locked P grant, then M alone.
        step(0, 0, 0, 0, 1, 1, 6, 6, 0, gm, gp);
        do_reset(1'b0);
        step(1, 0, 2, 3, 0, 0, 0, 0, 0, gm, gp);
        idle(3);

        // -65536 * -65536 = 2^32.
        step(1, 0, 'h10000, 'h10000, 0, 0, 0, 0, 0, gm, gp);
        idle(3);

        // Random traffic with locks, drops, flushes and occasional resets.
        mp = 0; pp = 0; ml = 0; pl = 0; ma = 0; mb = 0; pa = 0; pb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (mp == 0 && $urandom_range(0, 2) == 0) begin
                mp = 1; ml = ($urandom_range(0, 3) == 0) ? 1 : 0; ma = rnd_op(); mb = rnd_op();
            end
            if (pp == 0 && $urandom_range(0, 2) == 0) begin
                pp = 1; pl = ($urandom_range(0, 3) == 0) ? 1 : 0; pa = rnd_op(); pb = rnd_op();
            end
            fl = ($urandom_range(0, 24) == 0) ? 1 : 0;
            step(mp, ml, ma, mb, pp, pl, pa, pb, fl, gm, gp);
            if (gm) mp = 0;
            if (gp) pp = 0;
            if (mp != 0 && !gm && $urandom_range(0, 15) == 0) mp = 0;
            if (pp != 0 && !gp && $urandom_range(0, 15) == 0) pp = 0;
            if (i % 700 == 699) do_reset(mp != 0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
